lcd_frame_sched: RTL

//  Frame/line scheduler for the LCD pixel path. Sequences start-up, vertical sync, horizontal

---
 rtl/lcd_frame_sched.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/lcd_frame_sched.sv
// Frame/line scheduler for the LCD pixel path: sequences start-up, vsync, hsync and active
// data phases, pulls pixel pairs over valid/ready and emits registered, position-tagged pairs.
module lcd_frame_sched #(
  parameter int unsigned W_SIZE    = 12,
  parameter int unsigned W_DELAY   = 12,
  parameter int unsigned IMG_PIX_W = 8,
  parameter int unsigned W_FCNT    = 16
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic [W_SIZE-1:0]        cfg_width,
  input  logic [W_SIZE-1:0]        cfg_height,
  input  logic [W_DELAY-1:0]       cfg_startup_dly,
  input  logic [W_DELAY-1:0]       cfg_vsync_dly,
  input  logic [W_DELAY-1:0]       cfg_hsync_dly,
  input  logic [W_DELAY-1:0]       cfg_frame_gap,
  input  logic                     cfg_continuous,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     pix_valid,
  input  logic [6*IMG_PIX_W-1:0]   pix_data,
  output logic                     pix_ready,
  output logic                     out_valid,
  output logic [6*IMG_PIX_W-1:0]   out_data,
  output logic [W_SIZE-1:0]        out_row,
  output logic [W_SIZE-1:0]        out_col,
  output logic                     out_vsync,
  output logic                     out_hsync,
  output logic                     busy,
  output logic                     frame_done,
  output logic [W_FCNT-1:0]        frame_cnt,
  output logic                     underflow
);

  localparam int unsigned W_PIX = 6 * IMG_PIX_W;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_STARTUP = 3'd1,
    S_VSYNC   = 3'd2,
    S_HSYNC   = 3'd3,
    S_DATA    = 3'd4,
    S_GAP     = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [W_DELAY-1:0]  r_cnt;
  logic [W_SIZE-1:0]   r_row;
  logic [W_SIZE-1:0]   r_col;
  logic                r_stop_pend;

  logic [W_SIZE-1:0]   r_width;
  logic [W_SIZE-1:0]   r_height;
  logic [W_DELAY-1:0]  r_startup_dly;
  logic [W_DELAY-1:0]  r_vsync_dly;
  logic [W_DELAY-1:0]  r_hsync_dly;
  logic [W_DELAY-1:0]  r_frame_gap;
  logic                r_continuous;

  logic                r_out_valid;
  logic [W_PIX-1:0]    r_out_data;
  logic [W_SIZE-1:0]   r_out_row;
  logic [W_SIZE-1:0]   r_out_col;
  logic                r_vsync;
  logic                r_hsync;
  logic                r_busy;
  logic                r_frame_done;
  logic [W_FCNT-1:0]   r_frame_cnt;
  logic                r_underflow;

  logic [W_SIZE-1:0]   w_cfg_width;
  logic                w_start_ok;
  logic                w_hs;
  logic                w_eol;
  logic                w_last_row;
  logic                w_eof;
  logic                w_cont_next;

  // Odd widths are rounded down to whole pixel pairs
  assign w_cfg_width = cfg_width & ~W_SIZE'(1);
  assign w_start_ok  = (r_state == S_IDLE) && start && !stop &&
                       (w_cfg_width >= W_SIZE'(2)) && (cfg_height != '0);

  assign pix_ready   = (r_state == S_DATA);
  assign w_hs        = pix_valid && pix_ready;
  assign w_eol       = w_hs && (r_col == (r_width - W_SIZE'(2)));
  assign w_last_row  = (r_row == (r_height - W_SIZE'(1)));
  assign w_eof       = w_eol && w_last_row;
  assign w_cont_next = r_continuous && !r_stop_pend && !stop;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_start_ok) w_state_nxt = S_STARTUP;
      S_STARTUP: if (r_cnt == r_startup_dly) w_state_nxt = S_VSYNC;
      S_VSYNC:   if (r_cnt == r_vsync_dly) w_state_nxt = S_HSYNC;
      S_HSYNC:   if (r_cnt == r_hsync_dly) w_state_nxt = S_DATA;
      S_DATA: begin
        if (w_eof)      w_state_nxt = w_cont_next ? S_GAP : S_IDLE;
        else if (w_eol) w_state_nxt = S_HSYNC;
      end
      S_GAP:     if (r_cnt == r_frame_gap) w_state_nxt = S_VSYNC;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Phase counter restarts on every state entry; idle and data phases do not time anything
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_cnt <= '0;
    end else if ((w_state_nxt != r_state) || (r_state == S_IDLE) || (r_state == S_DATA)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + W_DELAY'(1);
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_width       <= '0;
      r_height      <= '0;
      r_startup_dly <= '0;
      r_vsync_dly   <= '0;
      r_hsync_dly   <= '0;
      r_frame_gap   <= '0;
      r_continuous  <= 1'b0;
    end else if (w_start_ok) begin
      r_width       <= w_cfg_width;
      r_height      <= cfg_height;
      r_startup_dly <= cfg_startup_dly;
      r_vsync_dly   <= cfg_vsync_dly;
      r_hsync_dly   <= cfg_hsync_dly;
      r_frame_gap   <= cfg_frame_gap;
      r_continuous  <= cfg_continuous;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_start_ok) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_hs) begin
      if (w_eol) begin
        r_col <= '0;
        r_row <= w_last_row ? '0 : r_row + W_SIZE'(1);
      end else begin
        r_col <= r_col + W_SIZE'(2);
      end
    end
  end

  // A stop seen while busy lets the current frame finish, then parks in idle
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_stop_pend <= 1'b0;
    end else if ((r_state == S_IDLE) || w_eof) begin
      r_stop_pend <= 1'b0;
    end else if (stop) begin
      r_stop_pend <= 1'b1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_row   <= '0;
      r_out_col   <= '0;
    end else begin
      r_out_valid <= w_hs;
      if (w_hs) begin
        r_out_data <= pix_data;
        r_out_row  <= r_row;
        r_out_col  <= r_col;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_vsync      <= 1'b0;
      r_hsync      <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_cnt  <= '0;
      r_underflow  <= 1'b0;
    end else begin
      r_vsync      <= (w_state_nxt == S_VSYNC);
      r_hsync      <= (w_state_nxt == S_HSYNC);
      r_busy       <= (w_state_nxt != S_IDLE);
      r_frame_done <= w_eof;
      if (w_eof) r_frame_cnt <= r_frame_cnt + W_FCNT'(1);
      if (w_start_ok)
        r_underflow <= 1'b0;
      else if ((r_state == S_DATA) && !pix_valid)
        r_underflow <= 1'b1;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_row    = r_out_row;
  assign out_col    = r_out_col;
  assign out_vsync  = r_vsync;
  assign out_hsync  = r_hsync;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign frame_cnt  = r_frame_cnt;
  assign underflow  = r_underflow;

endmodule
